// File: rtl/scan_pkg.sv
// Shared types and helpers for the minterm scanner: FSM state encoding,
// default sizing and the truth-table bit-position mapping.
package scan_pkg;

    localparam int DEF_N_VARS  = 4;
    localparam int DEF_N_FUNCS = 2;
    localparam int TT_W        = DEF_N_FUNCS << DEF_N_VARS;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } scan_state_t;

    // Bit k*2^n_vars + m of a packed table holds f_k(m).
    function automatic int tt_bit(input int k, input int m, input int n_vars);
        return (k << n_vars) + m;
    endfunction

endpackage

// File: rtl/scan_ctr.sv
// Minterm index counter. One bit wider than the vector so that the
// end-of-scan compare cannot alias against a wrapped index.
module scan_ctr #(
    parameter int N_VARS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [N_VARS-1:0] o_vec,
    output logic              o_last
);

    localparam logic [N_VARS:0] LAST_IDX = (N_VARS+1)'((1 << N_VARS) - 1);

    logic [N_VARS:0] r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_vec  = r_idx[N_VARS-1:0];
    assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/minterm_scanner.sv
// Sweeps every input vector into the function under test, packs the sampled
// outputs into a truth table and compares it against an expected mask.
module minterm_scanner
    import scan_pkg::*;
#(
    parameter int N_VARS  = DEF_N_VARS,
    parameter int N_FUNCS = DEF_N_FUNCS
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    output logic [N_VARS-1:0]                 o_vec_out,
    input  logic [N_FUNCS-1:0]                i_f_in,
    input  logic [(N_FUNCS << N_VARS)-1:0]    i_exp_tt,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [(N_FUNCS << N_VARS)-1:0]    o_tt_out,
    output logic [N_FUNCS-1:0]                o_mismatch,
    output logic [N_VARS-1:0]                 o_first_err
);

    localparam int TW    = N_FUNCS << N_VARS;
    localparam int TT_AW = $clog2(TW);

    scan_state_t          r_state;
    scan_state_t          w_next;
    logic                 w_clr;
    logic                 w_sample;
    logic                 w_busy;
    logic [N_VARS-1:0]    w_idx;
    logic                 w_last;
    logic [TT_AW-1:0]     w_pos [N_FUNCS];
    logic [N_FUNCS-1:0]   w_diff;
    logic [TW-1:0]        w_tt_next;

    logic                 r_done;
    logic [TW-1:0]        r_tt;
    logic [N_FUNCS-1:0]   r_mismatch;
    logic [N_VARS-1:0]    r_first_err;
    logic                 r_err_seen;

    scan_ctr #(.N_VARS(N_VARS)) u_ctr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_sample),
        .o_vec   (w_idx),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_clr    = 1'b0;
        w_sample = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_next = DRIVE;
                    w_clr  = 1'b1;
                end
            end
            DRIVE: begin
                w_busy = 1'b1;
                w_next = SAMPLE;
            end
            SAMPLE: begin
                w_busy   = 1'b1;
                w_sample = 1'b1;
                w_next   = w_last ? DONE : DRIVE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Each function's sample lands at its own table slot; compare against the same slot of exp_tt.
    always_comb begin
        w_tt_next = r_tt;
        w_diff    = '0;
        for (int k = 0; k < N_FUNCS; k++) begin
            w_pos[k]            = TT_AW'(tt_bit(k, int'(w_idx), N_VARS));
            w_tt_next[w_pos[k]] = i_f_in[k];
            w_diff[k]           = i_f_in[k] ^ i_exp_tt[w_pos[k]];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done      <= 1'b0;
            r_tt        <= '0;
            r_mismatch  <= '0;
            r_first_err <= '0;
            r_err_seen  <= 1'b0;
        end else if (w_clr) begin
            r_done      <= 1'b0;
            r_tt        <= '0;
            r_mismatch  <= '0;
            r_first_err <= '0;
            r_err_seen  <= 1'b0;
        end else if (w_sample) begin
            r_tt       <= w_tt_next;
            r_mismatch <= r_mismatch | w_diff;
            r_done     <= w_last;
            if ((|w_diff) && !r_err_seen) begin
                r_first_err <= w_idx;
                r_err_seen  <= 1'b1;
            end
        end
    end

    assign o_vec_out   = w_idx;
    assign o_busy      = w_busy;
    assign o_done      = r_done;
    assign o_tt_out    = r_tt;
    assign o_mismatch  = r_mismatch;
    assign o_first_err = r_first_err;

endmodule
